// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: takes one load or store from execute, issues a word-aligned
// memory request with byte-lane mask, and returns formatted load data or an error.
module ysyx_23060201_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        mem_rsp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_RESP} state_e;

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        off;
    logic [3:0]        lane_mask;
    logic [31:0]       rsp_shifted;
    logic [31:0]       load_fmt;
    logic              misaligned;
    logic [CNT_W-1:0]  cnt_inc;

    assign off         = addr_q[1:0];
    assign rsp_shifted = mem_rsp_rdata >> {off, 3'b000};
    assign cnt_inc     = cnt_q + 1'b1;

    always_comb begin
        lane_mask = 4'b1111;
        case (size_q)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        load_fmt = rsp_shifted;
        case (size_q)
            2'b00:   load_fmt = {{24{~uns_q & rsp_shifted[7]}}, rsp_shifted[7:0]};
            2'b01:   load_fmt = {{16{~uns_q & rsp_shifted[15]}}, rsp_shifted[15:0]};
            default: load_fmt = rsp_shifted;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (in_size)
            2'b01:   misaligned = in_addr[0];
            2'b10:   misaligned = (in_addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    wen_d   = in_wen;
                    size_d  = in_size;
                    uns_d   = in_unsigned;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    rdata_d = '0;
                    err_d   = misaligned;
                    state_d = misaligned ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                cnt_d = cnt_inc;
                // A response in the timeout cycle takes priority over the error.
                if (mem_rsp_valid) begin
                    rdata_d = wen_q ? '0 : load_fmt;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wen_q   <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE) & ~rst;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_rsp_ready = (state_q == S_WAIT_RSP);
    assign out_valid     = (state_q == S_RESP);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;

    // Request fields are only driven while a request is outstanding.
    assign mem_req_wen   = mem_req_valid & wen_q;
    assign mem_req_addr  = mem_req_valid ? {addr_q[31:2], 2'b00} : '0;
    assign mem_req_wdata = mem_req_valid ? (wdata_q << {off, 3'b000}) : '0;
    assign mem_req_wmask = (mem_req_valid & wen_q) ? lane_mask : '0;

endmodule

// File: doc/ysyx_23060201_lsu.md
Name: ysyx_23060201_lsu

Overview:
Load/store unit: the initiator side of the CPU data-memory interface. It accepts one load or store at a time from the execute stage and issues a word-aligned request with byte-lane mask to the memory responder. It waits for the memory response, then returns sign- or zero-extended load data (or a store acknowledge) to writeback. Misaligned accesses and memory timeouts are reported as errors instead of being issued or hanging.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT_RSP before giving up with out_err=1; a value of 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
in_valid  input  1  EXU request valid
in_ready  output  1  LSU can accept a request
in_wen  input  1  1=store, 0=load
in_size  input  2  00 byte, 01 half, 10 word, 11 illegal
in_unsigned  input  1  load zero-extend (1) or sign-extend (0); ignored for stores
in_addr  input  32  byte address
in_wdata  input  32  store data, right-aligned
out_valid  output  1  result valid to WBU
out_ready  input  1  WBU accepts result
out_rdata  output  32  formatted load data; 0 for stores and errors
out_err  output  1  misaligned, illegal size, or timeout
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_wen  output  1  request is a write
mem_req_addr  output  32  {addr[31:2],2'b00}
mem_req_wdata  output  32  lane-shifted store data
mem_req_wmask  output  4  byte-lane enables; 0 for reads
mem_rsp_valid  input  1  memory response valid (reads and writes)
mem_rsp_rdata  input  32  raw word read data
mem_rsp_ready  output  1  LSU accepts response

Behaviour:
- States: IDLE, REQ, WAIT_RSP, RESP. Reset → IDLE. All mem_req_*, mem_rsp_ready, out_valid, out_err and out_rdata are 0, and the timeout counter is 0.
- in_ready = (state==IDLE) & ~rst. mem_req_valid = (state==REQ). mem_rsp_ready = (state==WAIT_RSP). out_valid = (state==RESP).
- IDLE, on in_valid&in_ready: latch wen, size, unsigned, addr and wdata.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) or size 11 → go to RESP with out_err=1 and out_rdata=0. No memory request is issued.
  - Otherwise → REQ.
- REQ: hold all mem_req_* stable until mem_req_valid&mem_req_ready, then → WAIT_RSP with the counter cleared.
- Write lane rules, with off = addr[1:0]:
  - wmask: byte = 4'b0001<<off, half = 4'b0011<<off, word = 4'b1111.
  - wdata = in_wdata<<(8*off); bits outside the mask are don't-care but driven deterministically.
- WAIT_RSP: on mem_rsp_valid, capture the response → RESP.
  - Load: shift rdata right by 8*off, then extend from bit 7 (byte) or bit 15 (half) per unsigned.
  - Store: out_rdata = 0.
  - out_err = 0 in both cases.
- WAIT_RSP timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without mem_rsp_valid → RESP with out_err=1 and out_rdata=0. A response arriving in that same cycle wins: it is accepted and there is no error.
- A response arriving while not in WAIT_RSP is ignored (mem_rsp_ready=0).
- RESP: hold out_* stable until out_ready, then → IDLE.
  - in_ready is 0 in RESP, so a back-to-back request is accepted one cycle after the handshake.
- Minimum latency with mem ready and response each the same cycle they are awaited: accept at cycle 0, REQ at cycle 1, WAIT_RSP at cycle 2, out_valid at cycle 3.
- Reset mid-operation in any state: return to IDLE next edge, drop all valids, discard the latched request.

Test Plan:
- Load word addr 0x8000_0004, rsp 0xDEAD_BEEF, all ready=1 → mem_req_addr=0x8000_0004, wmask=0, out_rdata=0xDEAD_BEEF, out_valid exactly 3 cycles after accept.
- Load signed byte addr 0x...03, rsp 0x80FF_FFFF → out_rdata=0xFFFF_FF80. Same request with unsigned → 0x0000_0080. Half at off 2, rsp 0x8001_0000, signed → 0xFFFF_8001.
- Store half 0x1234 to addr 0x...02 with mem_req_ready held low for 4 cycles → req fields stable throughout; wmask=4'b1100, wdata=0x1234_0000; out_rdata=0, out_err=0 after rsp.
- Word load at addr 0x...02, and size=11 → out_err=1 with no mem_req_valid pulse; in_ready low until out_ready is seen.
- TIMEOUT_CYCLES=4, no response → out_err=1 after 4 cycles in WAIT_RSP. Repeat with rsp arriving on the 4th cycle → out_err=0 with data.
- Assert rst while in WAIT_RSP, then inject a late rsp → LSU in IDLE, in_ready=1, no out_valid.
